// File: rtl/pgm_rd.sv
// PGM read side: forwards bypass packets unchanged, or replays the packet stored
// in PGM_RAM repeatedly with a fixed idle gap until told to finish.
module pgm_rd #(
  parameter string PLATFORM   = "Xilinx",
  parameter int    GAP_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1023:0] in_rd_phv,
  input  logic          in_rd_phv_wr,
  input  logic [133:0]  in_rd_data,
  input  logic          in_rd_data_wr,
  input  logic          in_rd_valid,
  input  logic          in_rd_valid_wr,
  input  logic          pgm_bypass_flag,
  input  logic          pgm_sent_start_flag,
  input  logic          pgm_sent_finish_flag,
  output logic          rd2ram_rd_en,
  output logic [6:0]    rd2ram_addr,
  input  logic [143:0]  ram2rd_rdata,
  output logic [1023:0] out_rd_phv,
  output logic          out_rd_phv_wr,
  output logic [133:0]  out_rd_data,
  output logic          out_rd_data_wr,
  output logic          out_rd_valid,
  output logic          out_rd_valid_wr,
  input  logic          in_rd_alf,
  output logic [31:0]   gen_pkt_cnt
);

  typedef enum logic [2:0] {IDLE, BYPASS, GEN_RD, GEN_GAP, DONE} state_t;

  // A zero gap still needs one cycle in GEN_GAP to make the boundary decision.
  localparam logic [7:0] GAP_END = (GAP_CYCLES == 0) ? 8'd1 : 8'(GAP_CYCLES);

  state_t       r_state;
  logic         r_start_d;
  logic         r_fin;
  logic         r_pend;
  logic [6:0]   r_pend_addr;
  logic         r_first;
  logic [7:0]   r_gap;

  logic         w_start_edge;
  logic         w_byp_head;
  logic         w_byp_tail;
  logic [133:0] w_ram_word;
  logic         w_gen_tail;
  logic         w_fin;
  logic         w_gap_done;
  logic         w_unused;

  assign w_start_edge = pgm_sent_start_flag & ~r_start_d;
  assign w_byp_head   = in_rd_data_wr & (in_rd_data[133:132] == 2'b01) & pgm_bypass_flag;
  assign w_byp_tail   = in_rd_data_wr & (in_rd_data[133:132] == 2'b10);
  assign w_ram_word   = ram2rd_rdata[133:0];
  // The last RAM address always closes the packet, tail marker or not.
  assign w_gen_tail   = (w_ram_word[133:132] == 2'b10) | (r_pend_addr == 7'd127);
  assign w_fin        = r_fin | pgm_sent_finish_flag;
  assign w_gap_done   = (r_gap == GAP_END);

  // RAM sideband bits and the vendor tag do not affect this datapath.
  assign w_unused = &{1'b0, ram2rd_rdata[143:134], (PLATFORM == "Xilinx")};

  // NOTE: every register, outputs included, is cleared asynchronously and
  // updated with non-blocking assignments so all reads see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_start_d       <= 1'b1;  // a start level held through reset is not an edge
      r_fin           <= 1'b0;
      r_pend          <= 1'b0;
      r_pend_addr     <= '0;
      r_first         <= 1'b0;
      r_gap           <= '0;
      rd2ram_rd_en    <= 1'b0;
      rd2ram_addr     <= '0;
      out_rd_phv      <= '0;
      out_rd_phv_wr   <= 1'b0;
      out_rd_data     <= '0;
      out_rd_data_wr  <= 1'b0;
      out_rd_valid    <= 1'b0;
      out_rd_valid_wr <= 1'b0;
      gen_pkt_cnt     <= '0;
    end else begin
      r_start_d       <= pgm_sent_start_flag;
      r_pend          <= rd2ram_rd_en;
      r_pend_addr     <= rd2ram_addr;
      out_rd_phv_wr   <= 1'b0;
      out_rd_data_wr  <= 1'b0;
      out_rd_valid_wr <= 1'b0;

      unique case (r_state)
        IDLE: begin
          if (w_byp_head) begin
            r_state         <= BYPASS;
            out_rd_phv      <= in_rd_phv;
            out_rd_phv_wr   <= in_rd_phv_wr;
            out_rd_data     <= in_rd_data;
            out_rd_data_wr  <= in_rd_data_wr;
            out_rd_valid    <= in_rd_valid;
            out_rd_valid_wr <= in_rd_valid_wr;
          end else if (w_start_edge && !in_rd_alf) begin
            r_state      <= GEN_RD;
            rd2ram_rd_en <= 1'b1;
            rd2ram_addr  <= '0;
            r_first      <= 1'b1;
          end
        end

        BYPASS: begin
          out_rd_phv      <= in_rd_phv;
          out_rd_phv_wr   <= in_rd_phv_wr;
          out_rd_data     <= in_rd_data;
          out_rd_data_wr  <= in_rd_data_wr;
          out_rd_valid    <= in_rd_valid;
          out_rd_valid_wr <= in_rd_valid_wr;
          if (w_byp_tail) r_state <= IDLE;
        end

        GEN_RD: begin
          if (pgm_sent_finish_flag) r_fin <= 1'b1;
          if (r_pend) begin
            out_rd_data    <= {(w_gen_tail ? 2'b10 : w_ram_word[133:132]), w_ram_word[131:0]};
            out_rd_data_wr <= 1'b1;
            out_rd_phv_wr  <= r_first;
            out_rd_valid   <= w_gen_tail;
            if (r_first) out_rd_phv <= '0;
            r_first        <= 1'b0;
          end
          // The read issued alongside the tail word is simply never consumed.
          if (r_pend && w_gen_tail) begin
            rd2ram_rd_en    <= 1'b0;
            out_rd_valid_wr <= 1'b1;
            gen_pkt_cnt     <= gen_pkt_cnt + 32'd1;
            r_gap           <= 8'd1;
            r_state         <= GEN_GAP;
          end else if (rd2ram_addr == 7'd127) begin
            rd2ram_rd_en <= 1'b0;
          end else if (rd2ram_rd_en) begin
            rd2ram_addr <= rd2ram_addr + 7'd1;
          end
        end

        GEN_GAP: begin
          if (pgm_sent_finish_flag) r_fin <= 1'b1;
          if (!w_gap_done) begin
            r_gap <= r_gap + 8'd1;
          end else if (w_fin) begin
            r_state <= DONE;
          end else if (!in_rd_alf) begin
            r_state      <= GEN_RD;
            rd2ram_rd_en <= 1'b1;
            rd2ram_addr  <= '0;
            r_first      <= 1'b1;
          end
        end

        DONE: begin
          r_fin   <= 1'b0;
          r_state <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pgm_rd.sv
// Directed bench for pgm_rd: bypass passthrough, packet generation with gaps,
// finish handling, address-127 forced tail, almost-full hold and mid-packet reset.
module tb_pgm_rd;

  localparam int GAP = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1023:0] in_rd_phv;
  logic          in_rd_phv_wr;
  logic [133:0]  in_rd_data;
  logic          in_rd_data_wr;
  logic          in_rd_valid;
  logic          in_rd_valid_wr;
  logic          pgm_bypass_flag;
  logic          pgm_sent_start_flag;
  logic          pgm_sent_finish_flag;
  logic          rd2ram_rd_en;
  logic [6:0]    rd2ram_addr;
  logic [143:0]  ram2rd_rdata = '0;
  logic [1023:0] out_rd_phv;
  logic          out_rd_phv_wr;
  logic [133:0]  out_rd_data;
  logic          out_rd_data_wr;
  logic          out_rd_valid;
  logic          out_rd_valid_wr;
  logic          in_rd_alf;
  logic [31:0]   gen_pkt_cnt;

  int n_vec = 0;
  int n_err = 0;
  int n_stray = 0;
  int unsigned cyc = 0;

  logic [133:0] ram [128];
  logic [133:0] q_word [$];
  logic [3:0]   q_flag [$];   // {valid_wr, valid, phv_wr, phv==0}
  int unsigned  q_wcyc [$];
  logic [6:0]   q_addr [$];
  int unsigned  q_acyc [$];

  pgm_rd #(.PLATFORM("Xilinx"), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_rd_phv(in_rd_phv), .in_rd_phv_wr(in_rd_phv_wr),
    .in_rd_data(in_rd_data), .in_rd_data_wr(in_rd_data_wr),
    .in_rd_valid(in_rd_valid), .in_rd_valid_wr(in_rd_valid_wr),
    .pgm_bypass_flag(pgm_bypass_flag),
    .pgm_sent_start_flag(pgm_sent_start_flag),
    .pgm_sent_finish_flag(pgm_sent_finish_flag),
    .rd2ram_rd_en(rd2ram_rd_en), .rd2ram_addr(rd2ram_addr),
    .ram2rd_rdata(ram2rd_rdata),
    .out_rd_phv(out_rd_phv), .out_rd_phv_wr(out_rd_phv_wr),
    .out_rd_data(out_rd_data), .out_rd_data_wr(out_rd_data_wr),
    .out_rd_valid(out_rd_valid), .out_rd_valid_wr(out_rd_valid_wr),
    .in_rd_alf(in_rd_alf), .gen_pkt_cnt(gen_pkt_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: data valid the cycle after the read enable, junk in the sideband.
  always @(posedge clk) if (rd2ram_rd_en) ram2rd_rdata <= {10'h2A5, ram[rd2ram_addr]};

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_rd_data_wr) begin
        q_word.push_back(out_rd_data);
        q_flag.push_back({out_rd_valid_wr, out_rd_valid, out_rd_phv_wr, (out_rd_phv == '0)});
        q_wcyc.push_back(cyc);
      end
      if (rd2ram_rd_en) begin
        q_addr.push_back(rd2ram_addr);
        q_acyc.push_back(cyc);
      end
      if ((out_rd_phv_wr || out_rd_valid_wr) && !out_rd_data_wr) n_stray++;
    end
  end

  task automatic check(input string tag, input logic [133:0] got, input logic [133:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  function automatic logic [133:0] pkt_word(input int i, input logic [1:0] m);
    return {m, 4'h5, 64'hC0DE_0000_0000_0000 + 64'(i), 64'(i * 3 + 1)};
  endfunction

  function automatic logic [1:0] mark4(input int j);
    return (j == 0) ? 2'b01 : ((j == 3) ? 2'b10 : 2'b11);
  endfunction

  task automatic clear_q();
    q_word.delete(); q_flag.delete(); q_wcyc.delete();
    q_addr.delete(); q_acyc.delete();
  endtask

  task automatic load4();
    for (int i = 0; i < 128; i++) ram[i] = pkt_word(i, 2'b11);
    ram[0] = pkt_word(0, 2'b01);
    ram[3] = pkt_word(3, 2'b10);
  endtask

  task automatic load128();
    for (int i = 0; i < 128; i++) ram[i] = pkt_word(i, 2'b11);
    ram[0] = pkt_word(0, 2'b01);
  endtask

  task automatic start_edge();
    pgm_sent_start_flag = 1'b0;
    step();
    pgm_sent_start_flag = 1'b1;
  endtask

  task automatic finish_pulse();
    pgm_sent_finish_flag = 1'b1;
    step();
    pgm_sent_finish_flag = 1'b0;
  endtask

  task automatic wait_cnt(input logic [31:0] target, input string tag);
    int k = 0;
    while (gen_pkt_cnt != target && k < 400) begin
      step();
      k++;
    end
    check(tag, 134'(gen_pkt_cnt), 134'(target));
  endtask

  task automatic wait_words(input int n, input string tag);
    int k = 0;
    while (q_word.size() < n && k < 400) begin
      step();
      k++;
    end
    check(tag, 134'(q_word.size()), 134'(n));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [133:0]  bw [3];
    logic [1023:0] bphv;
    logic [133:0]  w;
    int            na;
    int            k;

    rst_n = 1'b0;
    in_rd_phv = '0; in_rd_phv_wr = 1'b0; in_rd_data = '0; in_rd_data_wr = 1'b0;
    in_rd_valid = 1'b0; in_rd_valid_wr = 1'b0; pgm_bypass_flag = 1'b0;
    pgm_sent_start_flag = 1'b0; pgm_sent_finish_flag = 1'b0; in_rd_alf = 1'b0;
    step(2);
    check("rst_rd_en",   134'(rd2ram_rd_en),   134'(0));
    check("rst_data_wr", 134'(out_rd_data_wr), 134'(0));
    check("rst_data",    out_rd_data,          134'(0));
    check("rst_cnt",     134'(gen_pkt_cnt),    134'(0));
    rst_n = 1'b1;
    step(2);

    // Bypass: 3-word packet must reappear unchanged one cycle later.
    bw[0] = {2'b01, {4{33'h0DEADBEEF}}};
    bw[1] = {2'b11, {4{33'h012345678}}};
    bw[2] = {2'b10, {4{33'h1CAFEF00D}}};
    bphv  = {32{32'hA5A5_0001}};
    for (int i = 0; i < 3; i++) begin
      in_rd_data = bw[i]; in_rd_data_wr = 1'b1; pgm_bypass_flag = 1'b1;
      in_rd_phv = bphv; in_rd_phv_wr = (i == 0);
      in_rd_valid = (i == 2); in_rd_valid_wr = (i == 2);
      step();
      check($sformatf("byp_data%0d", i),  out_rd_data,             bw[i]);
      check($sformatf("byp_dwr%0d", i),   134'(out_rd_data_wr),    134'(1));
      check($sformatf("byp_pwr%0d", i),   134'(out_rd_phv_wr),     134'(i == 0));
      check($sformatf("byp_vwr%0d", i),   134'(out_rd_valid_wr),   134'(i == 2));
      if (i == 0) check("byp_phv", 134'(out_rd_phv == bphv), 134'(1));
    end
    in_rd_phv_wr = 1'b0; in_rd_valid = 1'b0; in_rd_valid_wr = 1'b0;
    in_rd_data = {2'b11, 132'h77}; pgm_bypass_flag = 1'b0;
    step();
    check("byp_after_tail", 134'(out_rd_data_wr), 134'(0));
    in_rd_data_wr = 1'b0;
    step();
    check("byp_cnt", 134'(gen_pkt_cnt), 134'(0));
    check("byp_no_read", 134'(q_addr.size()), 134'(0));

    // Generation: 4-word packet replayed twice, finish during the gap.
    load4();
    clear_q();
    start_edge();
    wait_cnt(32'd2, "gen_cnt2");
    finish_pulse();
    step(20);
    check("gen_words", 134'(q_word.size()), 134'(8));
    for (int j = 0; j < 8 && j < q_word.size(); j++) begin
      check($sformatf("gen_w%0d", j), q_word[j], pkt_word(j % 4, mark4(j % 4)));
      check($sformatf("gen_f%0d", j), 134'(q_flag[j]),
            134'({(j % 4 == 3), (j % 4 == 3), (j % 4 == 0), 1'b1}));
    end
    check("gen_reads", 134'(q_addr.size()), 134'(10));
    for (int j = 0; j < 10 && j < q_addr.size(); j++)
      check($sformatf("gen_a%0d", j), 134'(q_addr[j]), 134'(j % 5));
    if (q_acyc.size() >= 6) check("gen_gap", 134'(q_acyc[5] - q_acyc[4]), 134'(GAP + 1));
    if (q_wcyc.size() >= 1 && q_acyc.size() >= 1)
      check("gen_latency", 134'(q_wcyc[0] - q_acyc[0]), 134'(2));

    // Finish while word 2 is on the output: packet completes, then nothing more.
    clear_q();
    start_edge();
    wait_words(2, "fin_w2");
    finish_pulse();
    step(20);
    check("fin_words", 134'(q_word.size()), 134'(4));
    if (q_flag.size() >= 4) check("fin_tail", 134'(q_flag[3]), 134'(4'b1101));
    check("fin_cnt",   134'(gen_pkt_cnt),   134'(3));
    check("fin_reads", 134'(q_addr.size()), 134'(5));
    if (q_acyc.size() >= 1 && q_wcyc.size() >= 1)
      check("fin_no_late_read", 134'(q_acyc[q_acyc.size() - 1] < q_wcyc[q_wcyc.size() - 1]), 134'(1));

    // No tail in RAM: all 128 words, last one forced to a tail.
    load128();
    clear_q();
    start_edge();
    wait_words(3, "w128_start");
    finish_pulse();
    wait_cnt(32'd4, "w128_cnt");
    step(20);
    check("w128_words", 134'(q_word.size()), 134'(128));
    if (q_word.size() == 128) begin
      w = pkt_word(127, 2'b10);
      check("w128_last", q_word[127], w);
      w = pkt_word(126, 2'b11);
      check("w128_prev", q_word[126], w);
      check("w128_flag", 134'(q_flag[127]), 134'(4'b1101));
    end
    check("w128_reads", 134'(q_addr.size()), 134'(128));
    if (q_addr.size() >= 1) check("w128_last_addr", 134'(q_addr[q_addr.size() - 1]), 134'(127));

    // Almost-full held during the gap blocks the next packet until it drops.
    load4();
    clear_q();
    start_edge();
    wait_cnt(32'd5, "alf_cnt5");
    in_rd_alf = 1'b1;
    na = q_addr.size();
    step(10);
    check("alf_hold", 134'(q_addr.size()), 134'(na));
    in_rd_alf = 1'b0;
    k = 0;
    while (q_addr.size() <= na && k < 50) begin
      step();
      k++;
    end
    check("alf_resume", 134'(q_addr.size() > na), 134'(1));
    if (q_addr.size() > na) check("alf_addr0", 134'(q_addr[na]), 134'(0));
    finish_pulse();
    wait_cnt(32'd6, "alf_cnt6");
    step(20);
    if (q_flag.size() >= 5) check("alf_head", 134'(q_flag[4]), 134'(4'b0011));

    // Reset during the first word of a packet.
    clear_q();
    start_edge();
    wait_words(1, "rst_w1");
    #2 rst_n = 1'b0;
    #1;
    check("mrst_rd_en",   134'(rd2ram_rd_en),    134'(0));
    check("mrst_addr",    134'(rd2ram_addr),     134'(0));
    check("mrst_data_wr", 134'(out_rd_data_wr),  134'(0));
    check("mrst_data",    out_rd_data,           134'(0));
    check("mrst_vwr",     134'(out_rd_valid_wr), 134'(0));
    check("mrst_cnt",     134'(gen_pkt_cnt),     134'(0));
    step(2);
    rst_n = 1'b1;
    clear_q();
    step(20);
    check("mrst_no_out",  134'(q_word.size()), 134'(0));
    check("mrst_no_read", 134'(q_addr.size()), 134'(0));
    start_edge();
    wait_cnt(32'd1, "mrst_regen");
    if (q_addr.size() >= 1) check("mrst_addr0", 134'(q_addr[0]), 134'(0));
    if (q_flag.size() >= 1) check("mrst_head", 134'(q_flag[0]), 134'(4'b0011));
    finish_pulse();
    step(20);

    check("stray_strobes", 134'(n_stray), 134'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
